multiplier_arbiter: RTL and testbench

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

---
 rtl/mult_arbiter_pkg.sv | 23 ++
 rtl/fixed_point_multiplier.sv | 76 +++++++
 rtl/multiplier_arbiter.sv | 148 ++++++++++++++
 tb/tb_multiplier_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared constants for the multiplier arbiter slice.
//   DATA_W          : operand / product width
//   DEFAULT_NUM_REQ : default number of requesters
//   SAT_MAX/SAT_MIN : signed saturation limits of the product
//   id_width()      : requester id width (clog2, minimum 1)
package mult_arbiter_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// Two-stage signed Q-format multiplier with round-half-up and saturation.
//   clk, reset : clock, synchronous active-high reset
//   enable     : operand capture strobe (one operation per strobe)
//   a, b       : signed operands
//   product    : signed rounded/saturated product, valid with done
//   done       : high two cycles after the enable cycle
module fixed_point_multiplier
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned EXP_WIDTH_A       = 15,
  parameter int unsigned EXP_WIDTH_B       = 15,
  parameter int unsigned EXP_WIDTH_PRODUCT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] product,
  output logic                     done
);

  localparam int SHIFT = int'(EXP_WIDTH_A + EXP_WIDTH_B) - int'(EXP_WIDTH_PRODUCT);
  localparam int unsigned FULL_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = FULL_W + 2;

  logic signed [FULL_W-1:0] mul_q;
  logic                     v1_q;
  logic                     done_q;
  logic signed [DATA_W-1:0] prod_q;

  logic signed [EXT_W-1:0]  ext_c;
  logic signed [EXT_W-1:0]  scaled_c;
  logic signed [DATA_W-1:0] sat_c;

  assign ext_c = EXT_W'(mul_q);

  // Rescale to the product Q-format; adding the first dropped bit gives round-half-up.
  generate
    if (SHIFT > 0) begin : g_shr
      logic signed [EXT_W-1:0] rbit_c;
      assign rbit_c   = {{(EXT_W-1){1'b0}}, mul_q[SHIFT-1]};
      assign scaled_c = (ext_c >>> SHIFT) + rbit_c;
    end else if (SHIFT == 0) begin : g_none
      assign scaled_c = ext_c;
    end else begin : g_shl
      assign scaled_c = ext_c <<< (-SHIFT);
    end
  endgenerate

  // Clamp to the signed 16-bit range.
  always_comb begin
    sat_c = scaled_c[DATA_W-1:0];
    if (scaled_c > 34'sd32767)       sat_c = SAT_MAX;
    else if (scaled_c < -34'sd32768) sat_c = SAT_MIN;
  end

  // Stage 1 captures the raw product, stage 2 the rounded/saturated result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_q  <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      v1_q   <= enable;
      done_q <= v1_q;
      if (enable) mul_q  <= FULL_W'(a) * FULL_W'(b);
      if (v1_q)   prod_q <= sat_c;
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NUM_REQ requesters.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : gates new grants; in-flight work still completes
//   req_valid    : per-requester request level
//   req_a, req_b : packed 16-bit signed operands, slice i = [16i+15:16i]
//   req_ready    : one-hot-or-zero grant (combinational)
//   resp_valid   : one-cycle pulse to the owner of resp_product
//   resp_product : rounded/saturated product
//   resp_id      : owner index of the response
//   in_flight    : accepted operations awaiting response (0..2)
module multiplier_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ           = DEFAULT_NUM_REQ,
  parameter int unsigned EXP_WIDTH_A       = 15,
  parameter int unsigned EXP_WIDTH_B       = 15,
  parameter int unsigned EXP_WIDTH_PRODUCT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]     req_a,
  input  logic [DATA_W*NUM_REQ-1:0]     req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]             resp_product,
  output logic [id_width(NUM_REQ)-1:0]  resp_id,
  output logic [1:0]                    in_flight
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               tag1_v_q, tag2_v_q;
  logic [ID_W-1:0]    tag1_id_q, tag2_id_q;
  logic [1:0]         in_flight_q;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    gid_c;
  logic [ID_W-1:0]    idx_c;
  logic [SUM_W-1:0]   sum_c;
  logic               found_c;
  logic               accept_c;
  logic [DATA_W-1:0]  op_a_c, op_b_c;
  logic [DATA_W-1:0]  mul_product;
  logic               mul_done;
  logic               resp_fire_c;

  // Round-robin search from the pointer upward, wrapping at NUM_REQ-1.
  always_comb begin
    grant_c = '0;
    gid_c   = '0;
    idx_c   = '0;
    sum_c   = '0;
    found_c = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum_c = {1'b0, ptr_q} + SUM_W'(off);
      if (sum_c >= SUM_W'(NUM_REQ)) sum_c = sum_c - SUM_W'(NUM_REQ);
      idx_c = sum_c[ID_W-1:0];
      if (!found_c && req_valid[idx_c]) begin
        found_c        = 1'b1;
        grant_c[idx_c] = 1'b1;
        gid_c          = idx_c;
      end
    end
    if (reset || !enable) grant_c = '0;
  end

  assign req_ready = grant_c;
  assign accept_c  = |grant_c;

  // Operand mux follows the one-hot grant.
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        op_a_c = req_a[i*DATA_W +: DATA_W];
        op_b_c = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_c) begin
      if (gid_c == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                             ptr_d = gid_c + ID_W'(1);
    end
  end

  // Tag pipeline mirrors the multiplier latency; in_flight tracks accepts minus responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      tag1_v_q    <= 1'b0;
      tag1_id_q   <= '0;
      tag2_v_q    <= 1'b0;
      tag2_id_q   <= '0;
      in_flight_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag1_v_q  <= accept_c;
      tag1_id_q <= gid_c;
      tag2_v_q  <= tag1_v_q;
      tag2_id_q <= tag1_id_q;
      case ({accept_c, mul_done})
        2'b10:   in_flight_q <= in_flight_q + 2'd1;
        2'b01:   in_flight_q <= in_flight_q - 2'd1;
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  fixed_point_multiplier #(
    .EXP_WIDTH_A       (EXP_WIDTH_A),
    .EXP_WIDTH_B       (EXP_WIDTH_B),
    .EXP_WIDTH_PRODUCT (EXP_WIDTH_PRODUCT)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .enable  (accept_c),
    .a       (op_a_c),
    .b       (op_b_c),
    .product (mul_product),
    .done    (mul_done)
  );

  // Responses follow the multiplier done; masked while reset is held.
  assign resp_fire_c = mul_done & ~reset;

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = resp_fire_c & (tag2_id_q == ID_W'(i));
    end
  end

  assign resp_id      = resp_fire_c ? tag2_id_q : '0;
  assign resp_product = reset ? '0 : mul_product;
  assign in_flight    = in_flight_q;

  // done and the stage-2 tag must always agree.
  a_done_tag : assert property (@(posedge clk) disable iff (reset) mul_done == tag2_v_q);

endmodule

// File: tb/tb_multiplier_arbiter.sv
module tb_multiplier_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_product;
  logic [1:0]  resp_id;
  logic [1:0]  in_flight;

  multiplier_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .in_flight    (in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
  } vec_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  int          cyc;
  int          ptr_m;
  bit          use_tbl;
  logic [15:0] tbl_prod;
  bit          accepted;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int off = 0; off < 4; off++) begin
      if (v[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  // Per-cycle check at the falling edge, then advance past the next rising edge.
  task automatic step();
    int   g;
    int   inf;
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (reset) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      chk("resp_valid_in_reset", 32'(resp_valid), 32'd0);
      chk("resp_product_in_reset", 32'(resp_product), 32'd0);
      chk("resp_id_in_reset", 32'(resp_id), 32'd0);
      sb.delete();
      ptr_m = 0;
    end else begin
      inf = 0;
      foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) inf++;
      chk("in_flight", 32'(in_flight), 32'(inf));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'd1 << e.id);
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_product", 32'(resp_product), 32'(e.prod));
      end else begin
        chk("resp_valid_idle", 32'(resp_valid), 32'd0);
      end
      g = enable ? model_grant(req_valid, ptr_m) : -1;
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (g >= 0) begin
        e.id   = g;
        e.prod = use_tbl ? tbl_prod : model_prod(req_a[16*g +: 16], req_b[16*g +: 16]);
        e.due  = cyc + 2;
        sb.push_back(e);
        ptr_m    = (g + 1) % 4;
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept(input string nm);
    for (int k = 0; k < 5 && !accepted; k++) step();
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_accept required=accept", nm);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  vec_t vecs[8];

  initial begin
    total = 0; bad = 0; cyc = 0; ptr_m = 0;
    use_tbl = 1'b0; tbl_prod = '0; accepted = 1'b0;
    reset = 1'b1; enable = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

    vecs[0] = '{2, 16'h4000, 16'h4000, 16'h2000};
    vecs[1] = '{0, 16'h8000, 16'h8000, 16'h7FFF};
    vecs[2] = '{1, 16'h7FFF, 16'h8000, 16'h8001};
    vecs[3] = '{3, 16'h0000, 16'h1234, 16'h0000};
    vecs[4] = '{2, 16'h4000, 16'hC000, 16'hE000};
    vecs[5] = '{1, 16'h0001, 16'h4000, 16'h0001};
    vecs[6] = '{0, 16'hFFFF, 16'h4000, 16'h0000};
    vecs[7] = '{3, 16'h7FFF, 16'h7FFF, 16'h7FFE};

    // Reset with all requesters valid, then stream continuously.
    @(posedge clk); #1;
    step();
    req_valid = 4'hF;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      step();
    end

    // Drop enable with two operations in flight.
    enable = 1'b0;
    drain(4);
    req_valid = '0;
    enable = 1'b1;
    drain(2);

    // Table of single-requester vectors with hand-computed products.
    use_tbl = 1'b1;
    foreach (vecs[v]) begin
      req_valid = 4'b1 << vecs[v].id;
      req_a = $urandom;
      req_b = $urandom;
      req_a[16*vecs[v].id +: 16] = vecs[v].a;
      req_b[16*vecs[v].id +: 16] = vecs[v].b;
      tbl_prod = vecs[v].prod;
      accepted = 1'b0;
      wait_accept("table_accept");
      req_valid = '0;
      drain(3);
    end
    use_tbl = 1'b0;

    // Reset one cycle after an accept discards it; next grant goes to 0.
    req_valid = 4'b0100;
    accepted = 1'b0;
    wait_accept("pre_reset_accept");
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 4'b1101;
    step();
    chk("post_reset_grant_ptr", 32'(ptr_m), 32'd1);
    req_valid = '0;
    drain(4);

    // Pointer wrap: pointer at 3 with requesters 3 and 0 valid.
    req_valid = 4'b0100;
    accepted = 1'b0;
    wait_accept("wrap_setup_accept");
    req_valid = 4'b1001;
    step();
    step();
    req_valid = 4'b0011;
    step();
    req_valid = '0;
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
